// File: rtl/instr_mem_responder.sv
// Instruction memory for the fetch stage: a byte-stream boot loader fills it while the core is held,
// then it serves one registered 32-bit instruction per cycle as the IF/DE instruction register.
module instr_mem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          ADDR_W      = $clog2(DEPTH_WORDS),
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        de_stall,
    input  logic        de_clear,
    output logic [31:0] instr,
    output logic        core_hold,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        err
);

    typedef enum logic [1:0] {LOAD, FLUSH, RUN} state_t;

    // word_ptr is one bit wider than the index so that "memory full" is representable.
    localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W + 1)'(DEPTH_WORDS);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

    state_t        state;
    logic [1:0]    byte_cnt;
    logic [ADDR_W:0] word_ptr;
    logic [31:0]   asm_word;
    logic [31:0]   asm_next;
    logic [31:0]   wr_data;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          accept;
    logic          complete;
    logic          ptr_full;
    logic          mem_we;
    logic          addr_bad;

    always_comb begin
        accept   = (state == LOAD) && ld_valid;
        asm_next = asm_word;
        asm_next[{byte_cnt, 3'b000} +: 8] = ld_data;
        complete = (accept && (byte_cnt == 2'd3)) || (state == FLUSH);
        wr_data  = (state == FLUSH) ? asm_word : asm_next;
        ptr_full = (word_ptr == PTR_FULL);
        mem_we   = complete && !ptr_full;
        addr_bad = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
    end

    // Storage is never reset, so a reset keeps the loaded image until it is overwritten.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[word_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            byte_cnt  <= 2'd0;
            word_ptr  <= '0;
            asm_word  <= 32'd0;
            err       <= 1'b0;
            instr     <= NOP_INSTR;
            core_hold <= 1'b1;
            ld_ready  <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    instr <= NOP_INSTR;
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            asm_word <= 32'd0;
                            if (ptr_full) begin
                                err <= 1'b1;
                            end else begin
                                word_ptr <= word_ptr + PTR_ONE;
                            end
                            if (ld_last) begin
                                state     <= RUN;
                                core_hold <= 1'b0;
                                ld_ready  <= 1'b0;
                            end
                        end else begin
                            asm_word <= asm_next;
                            if (ld_last) begin
                                state    <= FLUSH;
                                ld_ready <= 1'b0;
                            end
                        end
                    end
                end
                FLUSH: begin
                    instr    <= NOP_INSTR;
                    asm_word <= 32'd0;
                    byte_cnt <= 2'd0;
                    if (ptr_full) begin
                        err <= 1'b1;
                    end else begin
                        word_ptr <= word_ptr + PTR_ONE;
                    end
                    state     <= RUN;
                    core_hold <= 1'b0;
                end
                RUN: begin
                    // Clear beats stall; a stalled or cleared cycle never flags a bad address.
                    if (de_clear) begin
                        instr <= NOP_INSTR;
                    end else if (!de_stall) begin
                        if (addr_bad) begin
                            instr <= NOP_INSTR;
                            err   <= 1'b1;
                        end else begin
                            instr <= mem[addr[ADDR_W+1:2]];
                        end
                    end
                end
                default: begin
                    state     <= LOAD;
                    instr     <= NOP_INSTR;
                    core_hold <= 1'b1;
                    ld_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: each driven cycle queues its expected outputs,
// which are popped and compared just after the clock edge that produces them.
module tb_instr_mem_responder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        de_stall;
    logic        de_clear;
    logic [31:0] instr;
    logic        core_hold;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        err;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic        err;
        logic        hold;
        logic        ready;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .de_stall  (de_stall),
        .de_clear  (de_clear),
        .instr     (instr),
        .core_hold (core_hold),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .err       (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic st, input logic cl,
                                 input logic v, input logic [7:0] d, input logic l,
                                 input logic [31:0] e_instr, input logic e_err,
                                 input logic e_hold, input logic e_ready);
        exp_t e;
        exp_t o;
        @(negedge clk);
        addr     = a;
        de_stall = st;
        de_clear = cl;
        ld_valid = v;
        ld_data  = d;
        ld_last  = l;
        e.tag   = tag;
        e.instr = e_instr;
        e.err   = e_err;
        e.hold  = e_hold;
        e.ready = e_ready;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        checkOutput({o.tag, ".instr"}, instr, o.instr);
        checkOutput({o.tag, ".err"}, {31'd0, err}, {31'd0, o.err});
        checkOutput({o.tag, ".core_hold"}, {31'd0, core_hold}, {31'd0, o.hold});
        checkOutput({o.tag, ".ld_ready"}, {31'd0, ld_ready}, {31'd0, o.ready});
    endtask

    task automatic loadByte(input string tag, input logic [7:0] d, input logic l,
                            input logic e_err, input logic e_hold, input logic e_ready);
        applyStimulus(tag, 32'd0, 1'b0, 1'b0, 1'b1, d, l, NOP, e_err, e_hold, e_ready);
    endtask

    task automatic readAddr(input string tag, input logic [31:0] a, input logic st, input logic cl,
                            input logic [31:0] e_instr, input logic e_err);
        applyStimulus(tag, a, st, cl, 1'b0, 8'h00, 1'b0, e_instr, e_err, 1'b0, 1'b0);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (3) applyStimulus("reset", 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, NOP, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  prog [8];
        logic [7:0]  b;
        logic [31:0] w;

        rst_n    = 1'b0;
        addr     = 32'd0;
        de_stall = 1'b0;
        de_clear = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        ld_last  = 1'b0;

        resetDut();

        // Two-word program, with one idle loader cycle in the middle.
        prog = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                applyStimulus("ld_gap", 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, NOP, 1'b0, 1'b1, 1'b1);
            end
            loadByte("ld_prog", prog[i], i == 7, 1'b0, i != 7, i != 7);
        end

        readAddr("rd_w0",        32'd0, 1'b0, 1'b0, 32'h00500093, 1'b0);
        readAddr("stall_hold",   32'd4, 1'b1, 1'b0, 32'h00500093, 1'b0);
        readAddr("stall_hold2",  32'd4, 1'b1, 1'b0, 32'h00500093, 1'b0);
        readAddr("rd_w1",        32'd4, 1'b0, 1'b0, 32'h00A00513, 1'b0);
        readAddr("stall_clear",  32'd0, 1'b1, 1'b1, NOP,          1'b0);
        readAddr("rd_w0_again",  32'd0, 1'b0, 1'b0, 32'h00500093, 1'b0);
        readAddr("stall_badadr", 32'd2, 1'b1, 1'b0, 32'h00500093, 1'b0);
        readAddr("clear_badadr", 32'd2, 1'b0, 1'b1, NOP,          1'b0);
        applyStimulus("run_ld_ignored", 32'd4, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1,
                      32'h00A00513, 1'b0, 1'b0, 1'b0);
        readAddr("err_misalign", 32'd2,         1'b0, 1'b0, NOP,          1'b1);
        readAddr("err_range",    32'(DEPTH * 4), 1'b0, 1'b0, NOP,         1'b1);
        readAddr("err_sticky",   32'd0,         1'b0, 1'b0, 32'h00500093, 1'b1);

        resetDut();

        // Partial word: three bytes, one FLUSH cycle, upper lane zero; word 1 survives reset.
        loadByte("ld_part", 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
        loadByte("ld_part", 8'hBB, 1'b0, 1'b0, 1'b1, 1'b1);
        loadByte("ld_part_last", 8'hCC, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("flush_exit", 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, NOP, 1'b0, 1'b0, 1'b0);
        readAddr("rd_partial", 32'd0, 1'b0, 1'b0, 32'h00CCBBAA, 1'b0);
        readAddr("rd_kept_w1", 32'd4, 1'b0, 1'b0, 32'h00A00513, 1'b0);

        resetDut();

        // Overflow: 20 bytes into a 4-word memory; the fifth word is dropped and flags err.
        for (int i = 0; i < 20; i++) begin
            b = 8'h10 + 8'(i);
            loadByte("ld_ovf", b, i == 19, i == 19, i != 19, i != 19);
        end
        for (int k = 0; k < 4; k++) begin
            b = 8'h10 + 8'(4 * k);
            w = {b + 8'd3, b + 8'd2, b + 8'd1, b};
            readAddr("rd_ovf", 32'(4 * k), 1'b0, 1'b0, w, 1'b1);
        end

        resetDut();

        // Mid-load reset: leftover bytes must not leak into the restarted load at word 0.
        loadByte("ld_abort", 8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
        loadByte("ld_abort", 8'h66, 1'b0, 1'b0, 1'b1, 1'b1);
        resetDut();
        loadByte("ld_restart", 8'h77, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("flush_exit2", 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, NOP, 1'b0, 1'b0, 1'b0);
        readAddr("rd_restart",    32'd0, 1'b0, 1'b0, 32'h00000077, 1'b0);
        readAddr("rd_restart_w1", 32'd4, 1'b0, 1'b0, 32'h17161514, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Instruction-memory responder serving the fetch stage: accepts the next-PC byte address each cycle and returns the addressed 32-bit instruction through a registered read port that acts as the IF/DE instruction register. It honours the decode-stage stall and clear directly. After reset, a byte-stream boot loader fills the memory with a program while the core is held. The block sits between the fetch stage and the program image source, such as a UART or debug bridge.

## Interface
Parameters:
- DEPTH_WORDS, 4096: number of 32-bit instruction words; must be a power of two.
- ADDR_W, $clog2(DEPTH_WORDS): word-index width; derived, not overridden.
- NOP_INSTR, 32'h00000013: bubble value driven on clear, reset, load and error.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- addr, input, 32: next-PC byte address from fetch (if_pc_next_instr_mem).
- de_stall, input, 1: hold the instruction register.
- de_clear, input, 1: flush the instruction register to NOP_INSTR.
- instr, output, 32: registered instruction to fetch/decode (if_instr_rd).
- core_hold, output, 1: high while not in RUN; the core ORs it into its stall and PC hold.
- ld_valid, input, 1: loader byte valid.
- ld_data, input, 8: loader byte; little-endian within each word.
- ld_last, input, 1: qualifies the final byte of the image.
- ld_ready, output, 1: loader may transfer.
- err, output, 1: sticky error flag; cleared only by reset.

## Operation
- FSM states: LOAD (reset state), FLUSH, RUN.
- **LOAD**
  - ld_ready=1. A byte is accepted when ld_valid && ld_ready.
  - Accepted bytes shift into a 32-bit assembly register at lane byte_cnt (0..3). byte_cnt is 2 bits and wraps.
  - On the 4th byte, write the assembled word to mem[word_ptr] and increment word_ptr.
  - A byte with ld_last: go to FLUSH if byte_cnt≠3; otherwise write the word and go straight to RUN.
- **FLUSH**
  - One cycle.
  - Write the partial word with unfilled upper lanes zero, then go to RUN.
  - ld_ready=0.
- **RUN**
  - ld_ready=0; loader inputs are ignored.
  - core_hold=0 only in RUN.
- **Overflow**
  - A byte that would complete a word with word_ptr == DEPTH_WORDS is discarded: no write and no wrap to 0.
  - Sets err. Loading continues to accept bytes until ld_last.
- **Read port** (RUN only), evaluated each edge in priority order:
  1. !rst_n → instr=NOP_INSTR.
  2. de_clear → instr=NOP_INSTR.
  3. de_stall → instr holds.
  4. Otherwise instr = mem[addr[ADDR_W+1:2]].
- **Read errors**
  - Error condition: addr[1:0]≠0 or addr[31:ADDR_W+2]≠0.
  - On an error, the non-stalled, non-cleared load writes NOP_INSTR to instr and sets err.
- **Outside RUN**
  - instr is forced to NOP_INSTR on every edge, regardless of de_stall and de_clear.
- **Reset**
  - Effects: state=LOAD, byte_cnt=0, word_ptr=0, assembly register=0, err=0, instr=NOP_INSTR.
  - Memory contents are not cleared. Mid-load reset restarts loading from word 0.

## Timing
- Reset values: instr=NOP_INSTR, core_hold=1, ld_ready=1, err=0.
- Read latency: 1 cycle. The addr presented before edge N produces instr valid after edge N. This matches fetch presenting the next PC, so instr corresponds to the PC registered at that same edge.
- de_clear and de_stall both high: clear wins.
- de_stall holds instr indefinitely; the stalled address is not re-read.
- Loader
  - One byte per cycle maximum.
  - ld_ready is a function of state only, not of ld_valid.
  - The memory write occurs on the same edge that accepts the 4th byte, or on the FLUSH edge.
- core_hold
  - Falls on the edge entering RUN.
  - The first valid fetch read is on the next edge. The fetch stage must present its reset PC address while core_hold=1.
- A write in the last LOAD/FLUSH cycle is visible to a read in the first RUN cycle (write-before-read ordering across cycles; no same-cycle read in LOAD).
- err rises on the edge after the offending byte or read; it never falls without reset.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles → instr=0x00000013, core_hold=1, ld_ready=1, err=0.
- **Load and read:**
  - Load bytes 93,00,50,00, then 13,05,A0,00 with ld_last on the 8th byte → mem[0]=0x00500093, mem[1]=0x00A00513, state RUN next edge, core_hold=0.
  - Then addr=0 then addr=4 → instr=0x00500093, then 0x00A00513, each one edge later.
- **Partial word:** load 3 bytes AA,BB,CC with ld_last on CC → one FLUSH cycle, mem[0]=0x00CCBBAA, then RUN.
- **Stall and clear:**
  - In RUN with instr=0x00500093: de_stall=1 while addr changes to 4 → instr unchanged.
  - de_stall=1 and de_clear=1 together → instr=0x00000013.
- **Errors:**
  - In RUN, addr=0x2 → instr=0x00000013, err=1.
  - addr=DEPTH_WORDS*4 → instr=0x00000013, err stays 1.
  - Reset → err=0.
- **Overflow and mid-load reset:**
  - With DEPTH_WORDS=4, load 20 bytes → words 0..3 written, 5th word discarded, err=1.
  - Reset after 2 bytes → next load writes from word 0.
